// File: rtl/qbert_move_ctrl.sv
// Q*bert jump initiator: turns one-shot direction requests into layer jump commands.
// Latency: ack/command one cycle after acceptance; requests seen while busy, paused or with the layer not IDLE are dropped.
module qbert_move_ctrl #(
    parameter int          N_CUBE  = 28,
    parameter logic [31:0] TIMEOUT = 32'd50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              e_start,
    input  logic              e_pause,
    input  logic              dir_valid,
    input  logic [2:0]        dir_req,
    input  logic [2:0]        state_qb,
    output logic              dir_ack,
    output logic [2:0]        e_jump_qb,
    output logic [N_CUBE-1:0] e_next_qb,
    output logic              e_bad_jump,
    output logic [N_CUBE-1:0] position_qb,
    output logic [N_CUBE-1:0] visited,
    output logic [4:0]        visited_cnt,
    output logic              level_done,
    output logic              busy,
    output logic              err_timeout
);
    localparam logic [2:0] LAYER_IDLE = 3'b010;
    localparam logic [N_CUBE-1:0] TOP = N_CUBE'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, MOVING, COMMIT} state_t;

    state_t            state_q, state_d;
    logic [N_CUBE-1:0] pos_q, pos_d, vis_q, vis_d, next_q, next_d;
    logic [2:0]        r_q, r_d, k_q, k_d, nr_q, nr_d, nk_q, nk_d, jump_q, jump_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [31:0]       tmo_q, tmo_d;
    logic              ack_q, ack_d, bad_q, bad_d, done_q, done_d, err_q, err_d;

    logic              legal, tgt_bad;
    logic [N_CUBE-1:0] tgt_pos;
    logic [2:0]        tgt_r, tgt_k;

    // Neighbour cube on the triangular pyramid is a fixed one-hot shift by row.
    always_comb begin
        legal   = 1'b1;
        tgt_pos = '0;
        tgt_bad = 1'b0;
        tgt_r   = r_q;
        tgt_k   = k_q;
        case (dir_req)
            3'b001: begin
                tgt_pos = pos_q << r_q;
                tgt_bad = (r_q == 3'd7);
                tgt_r   = r_q + 3'd1;
            end
            3'b010: begin
                tgt_pos = pos_q << ({1'b0, r_q} + 4'd1);
                tgt_bad = (r_q == 3'd7);
                tgt_r   = r_q + 3'd1;
                tgt_k   = k_q + 3'd1;
            end
            3'b011: begin
                tgt_pos = pos_q >> r_q;
                tgt_bad = (k_q == 3'd1);
                tgt_r   = r_q - 3'd1;
                tgt_k   = k_q - 3'd1;
            end
            3'b100: begin
                tgt_pos = pos_q >> (r_q - 3'd1);
                tgt_bad = (k_q == r_q);
                tgt_r   = r_q - 3'd1;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        vis_d   = vis_q;
        next_d  = next_q;
        r_d     = r_q;
        k_d     = k_q;
        nr_d    = nr_q;
        nk_d    = nk_q;
        jump_d  = jump_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        ack_d   = 1'b0;
        bad_d   = bad_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (dir_valid && legal && !e_pause && state_qb == LAYER_IDLE) begin
                    ack_d   = 1'b1;
                    jump_d  = dir_req;
                    next_d  = tgt_bad ? '0 : tgt_pos;
                    bad_d   = tgt_bad;
                    nr_d    = tgt_r;
                    nk_d    = tgt_k;
                    tmo_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (state_qb != LAYER_IDLE) begin
                    state_d = MOVING;
                end else if (tmo_q == TIMEOUT - 32'd1) begin
                    err_d   = 1'b1;
                    jump_d  = '0;
                    next_d  = '0;
                    bad_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            MOVING: begin
                if (state_qb == LAYER_IDLE) state_d = COMMIT;
            end
            COMMIT: begin
                if (bad_q) begin
                    pos_d = TOP;
                    r_d   = 3'd1;
                    k_d   = 3'd1;
                end else begin
                    pos_d = next_q;
                    r_d   = nr_q;
                    k_d   = nk_q;
                    vis_d = vis_q | next_q;
                    if ((vis_q & next_q) == '0) cnt_d = cnt_q + 5'd1;
                end
                jump_d  = '0;
                next_d  = '0;
                bad_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        done_d = (vis_d == {N_CUBE{1'b1}});
        // Restart wins over any in-flight command.
        if (e_start) begin
            state_d = IDLE;
            pos_d   = TOP;
            vis_d   = TOP;
            next_d  = '0;
            r_d     = 3'd1;
            k_d     = 3'd1;
            jump_d  = '0;
            cnt_d   = 5'd1;
            tmo_d   = '0;
            ack_d   = 1'b0;
            bad_d   = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pos_q   <= TOP;
            vis_q   <= TOP;
            next_q  <= '0;
            r_q     <= 3'd1;
            k_q     <= 3'd1;
            nr_q    <= 3'd1;
            nk_q    <= 3'd1;
            jump_q  <= '0;
            cnt_q   <= 5'd1;
            tmo_q   <= '0;
            ack_q   <= 1'b0;
            bad_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            vis_q   <= vis_d;
            next_q  <= next_d;
            r_q     <= r_d;
            k_q     <= k_d;
            nr_q    <= nr_d;
            nk_q    <= nk_d;
            jump_q  <= jump_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            ack_q   <= ack_d;
            bad_q   <= bad_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign dir_ack     = ack_q;
    assign e_jump_qb   = jump_q;
    assign e_next_qb   = next_q;
    assign e_bad_jump  = bad_q;
    assign position_qb = pos_q;
    assign visited     = vis_q;
    assign visited_cnt = cnt_q;
    assign level_done  = done_q;
    assign busy        = (state_q != IDLE);
    assign err_timeout = err_q;
endmodule

// File: tb/tb_qbert_move_ctrl.sv
// Scoreboarded bench for qbert_move_ctrl: commands predicted from a row/column pyramid model.
module tb_qbert_move_ctrl;
    localparam logic [31:0] TMO = 32'd16;
    localparam logic [2:0] L_IDLE = 3'b010, L_JUMP = 3'b011, L_KO = 3'b100, L_START = 3'b001;
    localparam logic [2:0] DR = 3'b001, DL = 3'b010, UR = 3'b011, UL = 3'b100;

    logic        clk = 1'b0, reset, e_start, e_pause, dir_valid;
    logic [2:0]  dir_req, state_qb;
    logic        dir_ack, e_bad_jump, level_done, busy, err_timeout;
    logic [2:0]  e_jump_qb;
    logic [27:0] e_next_qb, position_qb, visited;
    logic [4:0]  visited_cnt;

    qbert_move_ctrl #(.N_CUBE(28), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .e_start(e_start), .e_pause(e_pause),
        .dir_valid(dir_valid), .dir_req(dir_req), .state_qb(state_qb),
        .dir_ack(dir_ack), .e_jump_qb(e_jump_qb), .e_next_qb(e_next_qb),
        .e_bad_jump(e_bad_jump), .position_qb(position_qb), .visited(visited),
        .visited_cnt(visited_cnt), .level_done(level_done), .busy(busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  code;
        logic [27:0] nxt;
        logic        bad;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk = 0, n_fail = 0, ack_cnt = 0, m_acks = 0;
    int          m_r, m_k, m_cnt;
    logic [27:0] m_vis, m_pos;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [27:0] onehot(input int r, input int k);
        logic [27:0] v;
        int idx;
        v   = 28'd1;
        idx = r * (r - 1) / 2 + k;
        return v << (idx - 1);
    endfunction

    task automatic model_reset();
        m_r = 1; m_k = 1; m_cnt = 1; m_vis = 28'd1; m_pos = 28'd1;
    endtask

    task automatic predict(input logic [2:0] code, output logic bad, output int nr, output int nk);
        nr = m_r; nk = m_k; bad = 1'b0;
        case (code)
            DR: begin bad = (m_r == 7); nr = m_r + 1; end
            DL: begin bad = (m_r == 7); nr = m_r + 1; nk = m_k + 1; end
            UR: begin bad = (m_k == 1); nr = m_r - 1; nk = m_k - 1; end
            default: begin bad = (m_k == m_r); nr = m_r - 1; end
        endcase
    endtask

    // Scoreboard side: every ack pops the command predicted at drive time.
    always @(negedge clk) begin
        if (dir_ack) begin
            ack_cnt++;
            if (sb_q.size() == 0) begin
                check_eq("ack_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("jump_code", {29'd0, e_jump_qb}, {29'd0, e.code});
                check_eq("next_cube", {4'd0, e_next_qb}, {4'd0, e.nxt});
                check_eq("bad_jump", {31'd0, e_bad_jump}, {31'd0, e.bad});
            end
        end
    end

    task automatic issue(input logic [2:0] code, output logic bad, output int nr, output int nk);
        exp_t e;
        predict(code, bad, nr, nk);
        e.code = code;
        e.bad  = bad;
        e.nxt  = bad ? 28'd0 : onehot(nr, nk);
        sb_q.push_back(e);
        m_acks++;
        @(negedge clk);
        dir_valid = 1'b1;
        dir_req   = code;
        @(negedge clk);
        dir_valid = 1'b0;
        check_eq("busy_on_ack", {31'd0, busy}, 32'd1);
    endtask

    task automatic do_move(input logic [2:0] code);
        logic bad;
        int nr, nk;
        issue(code, bad, nr, nk);
        state_qb = L_JUMP;
        repeat (2) @(negedge clk);
        if (bad) begin
            state_qb = L_KO;
            repeat (2) @(negedge clk);
            state_qb = L_START;
            @(negedge clk);
        end
        state_qb = L_IDLE;
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        check_eq("move_done", {31'd0, busy}, 32'd0);
        if (bad) begin
            m_r = 1; m_k = 1; m_pos = 28'd1;
        end else begin
            m_r = nr; m_k = nk; m_pos = onehot(nr, nk);
            if ((m_vis & m_pos) == 28'd0) m_cnt++;
            m_vis = m_vis | m_pos;
        end
        check_eq("position", {4'd0, position_qb}, {4'd0, m_pos});
        check_eq("visited", {4'd0, visited}, {4'd0, m_vis});
        check_eq("visited_cnt", {27'd0, visited_cnt}, 32'(m_cnt));
        check_eq("level_done", {31'd0, level_done}, {31'd0, (m_vis == 28'hFFFFFFF)});
        check_eq("ack_count", 32'(ack_cnt), 32'(m_acks));
    endtask

    task automatic try_drop(input logic [2:0] code, input string tag);
        @(negedge clk);
        dir_valid = 1'b1;
        dir_req   = code;
        @(negedge clk);
        dir_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq(tag, 32'(ack_cnt), 32'(m_acks));
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        int nr, nk;
        reset = 1'b0; e_start = 1'b0; e_pause = 1'b0; dir_valid = 1'b0;
        dir_req = 3'b000; state_qb = L_IDLE;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_position", {4'd0, position_qb}, 32'h1);
        check_eq("rst_visited", {4'd0, visited}, 32'h1);
        check_eq("rst_cnt", {27'd0, visited_cnt}, 32'd1);
        check_eq("rst_jump", {29'd0, e_jump_qb}, 32'd0);
        check_eq("rst_next", {4'd0, e_next_qb}, 32'd0);
        check_eq("rst_bad", {31'd0, e_bad_jump}, 32'd0);
        check_eq("rst_ack", {31'd0, dir_ack}, 32'd0);
        check_eq("rst_level", {31'd0, level_done}, 32'd0);
        check_eq("rst_err", {31'd0, err_timeout}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);

        // First jump from the top, then the cube-5 neighbourhood.
        do_move(DR);
        check_eq("top_dr_pos", {4'd0, position_qb}, 32'h2);
        check_eq("top_dr_vis", {4'd0, visited}, 32'h3);
        do_move(DL);
        do_move(DL);
        check_eq("cube9", {4'd0, position_qb}, 32'h100);
        do_move(UR);
        do_move(UR);
        do_move(DL);
        do_move(UL);
        check_eq("cube3", {4'd0, position_qb}, 32'h4);

        // Off-pyramid jump from cube 4 through the KO sequence.
        do_move(DR);
        do_move(UR);
        do_move(DR);
        check_eq("cube4", {4'd0, position_qb}, 32'h8);
        do_move(UR);
        check_eq("bad_to_top", {4'd0, position_qb}, 32'h1);

        e_pause = 1'b1;
        try_drop(DR, "pause_drop");
        e_pause = 1'b0;
        try_drop(3'b000, "illegal_000");
        try_drop(3'b111, "illegal_111");

        // Layer never responds.
        issue(DR, bad, nr, nk);
        repeat (int'(TMO) + 4) @(negedge clk);
        check_eq("tmo_err", {31'd0, err_timeout}, 32'd1);
        check_eq("tmo_jump", {29'd0, e_jump_qb}, 32'd0);
        check_eq("tmo_next", {4'd0, e_next_qb}, 32'd0);
        check_eq("tmo_pos", {4'd0, position_qb}, {4'd0, m_pos});
        check_eq("tmo_busy", {31'd0, busy}, 32'd0);

        // Restart while the layer is mid-jump.
        issue(DR, bad, nr, nk);
        state_qb = L_JUMP;
        repeat (2) @(negedge clk);
        e_start = 1'b1;
        @(negedge clk);
        e_start = 1'b0;
        model_reset();
        check_eq("start_pos", {4'd0, position_qb}, 32'h1);
        check_eq("start_vis", {4'd0, visited}, 32'h1);
        check_eq("start_cnt", {27'd0, visited_cnt}, 32'd1);
        check_eq("start_jump", {29'd0, e_jump_qb}, 32'd0);
        check_eq("start_busy", {31'd0, busy}, 32'd0);
        check_eq("start_err", {31'd0, err_timeout}, 32'd0);
        state_qb = L_IDLE;
        @(negedge clk);

        // Zigzag walk over every cube; sideways steps revisit the row above.
        for (int r = 1; r <= 7; r++) begin
            for (int j = 1; j < r; j++) begin
                if (r % 2 == 1) begin do_move(UL); do_move(DL); end
                else begin do_move(UR); do_move(DR); end
            end
            if (r < 7) do_move((r % 2 == 1) ? DL : DR);
        end
        check_eq("walk_level_done", {31'd0, level_done}, 32'd1);
        check_eq("walk_cnt", {27'd0, visited_cnt}, 32'd28);
        do_move(UR);
        check_eq("revisit_cnt", {27'd0, visited_cnt}, 32'd28);

        // Asynchronous reset while waiting in ISSUE.
        issue(DL, bad, nr, nk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_pos", {4'd0, position_qb}, 32'h1);
        check_eq("arst_vis", {4'd0, visited}, 32'h1);
        check_eq("arst_jump", {29'd0, e_jump_qb}, 32'd0);
        check_eq("arst_next", {4'd0, e_next_qb}, 32'd0);
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_level", {31'd0, level_done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/qbert_move_ctrl.md
Name: qbert_move_ctrl

Overview:
- Initiator side of the Q*bert jump interface: converts one-shot direction requests (NIOS/accelerometer) into the jump command set consumed by the Q*bert display layer: e_jump_qb, e_next_qb, e_bad_jump and position_qb.
- Tracks the one-hot cube position on the 28-cube pyramid and the visited-cube mask, and flags level completion.
- Sits between the game/input logic and the Q*bert layer; the layer reports progress through state_qb.

Parameters:
- N_CUBE, 28, cubes in the pyramid (7 rows); position vectors are N_CUBE bits wide.
- TIMEOUT, 32'd50_000_000, clocks allowed in ISSUE before the command is abandoned.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- e_start  in  1  restart pulse from NIOS: return to TOP, clear the visited mask
- e_pause  in  1  level: freeze acceptance of new requests
- dir_valid  in  1  request strobe, one cycle
- dir_req  in  3  001 DOWN_RIGHT, 010 DOWN_LEFT, 011 UP_RIGHT, 100 UP_LEFT
- state_qb  in  3  Q*bert layer state (010 = IDLE)
- dir_ack  out  1  one-cycle pulse: request accepted
- e_jump_qb  out  3  jump code driven to the layer
- e_next_qb  out  28  one-hot target cube; 0 for a bad jump
- e_bad_jump  out  1  target is off the pyramid
- position_qb  out  28  one-hot current cube
- visited  out  28  cubes landed on since the last restart
- visited_cnt  out  5  popcount of visited
- level_done  out  1  visited == all ones
- busy  out  1  state != IDLE
- err_timeout  out  1  sticky; cleared by e_start

Behaviour:
- Geometry:
  - Cube (r,k) with row r = 1..7 and k = 1..r; index = r(r-1)/2 + k; bit index-1 is set in position.
  - k = 1 is the right edge (cubes 1,2,4,7,11,16,22); k = r is the left edge (cubes 1,3,6,10,15,21,28).
- Target (one-hot shift):

  | Code | Move | Target | Off-pyramid when |
  |---|---|---|---|
  | 001 | DOWN_RIGHT | pos << r | r = 7 |
  | 010 | DOWN_LEFT | pos << (r+1) | r = 7 |
  | 011 | UP_RIGHT | pos >> r | k = 1 |
  | 100 | UP_LEFT | pos >> (r-1) | k = r |

  - Current r and k are held in registers (3 bits each), updated on commit; they are not decoded from position.
  - dir_req values 000, 101, 110, 111 are ignored: no ack, no state change.
- Reset (asserted low, asynchronous):
  - position = 1, r = 1, k = 1, visited = 1, visited_cnt = 1.
  - e_jump_qb = 0, e_next_qb = 0, e_bad_jump = 0, dir_ack = 0, level_done = 0, err_timeout = 0.
  - state = IDLE.
- FSM, all transitions registered:
  - IDLE:
    - Accepts a request when dir_valid & legal code & !e_pause & state_qb == 010.
    - Next cycle: dir_ack = 1, e_jump_qb = code, e_next_qb / e_bad_jump = computed target → ISSUE.
    - A request that does not meet these conditions is dropped, not queued.
  - ISSUE:
    - Holds the outputs stable and waits for state_qb != 010 (layer accepted) → MOVING.
    - Timeout counter increments each cycle. At TIMEOUT: err_timeout = 1, e_jump_qb = 0, e_next_qb = 0 → IDLE, position unchanged.
  - MOVING:
    - e_jump_qb is kept; it stays stable through the layer's KO as well.
    - Waits for state_qb == 010 → COMMIT.
  - COMMIT (1 cycle):
    - Good jump: position = e_next_qb; r and k update; visited |= e_next_qb; visited_cnt increments only if the bit was new.
    - Bad jump: position = 1, r = 1, k = 1; visited unchanged.
    - Clears e_jump_qb, e_next_qb, e_bad_jump → IDLE.
- level_done is registered and equals (visited == 28'hFFFFFFF); visited_cnt == 28 when it is set.
- e_start has priority over everything in every state:
  - Next cycle, all outputs take their reset values except err_timeout, which is cleared.
- e_pause:
  - Blocks new acceptance only; an in-flight command completes.
- dir_ack fires at most once per accepted request. busy is high from the ack cycle through COMMIT.

Test Plan:
- Reset, then dir_req = 001 from TOP with the layer model going IDLE→JUMP→IDLE:
  - ack pulse; e_jump_qb = 001; e_next_qb = 28'h2; after commit position = 28'h2, visited = 28'h3, visited_cnt = 2.
- From cube 5 (r=3, k=2):
  - 010 gives next = cube 9 (28'h100).
  - 011 gives next = cube 2.
  - 100 gives next = cube 3.
- Bad jump, dir_req = 011 at cube 4 (r=3, k=1):
  - e_bad_jump = 1, e_next_qb = 0.
  - Layer goes JUMP→KO→START→IDLE; on commit position = 28'h1 and visited is unchanged.
- Timing and drop cases:
  - Layer never leaves IDLE: after TIMEOUT cycles err_timeout = 1, e_jump_qb = 0, position unchanged.
  - Pause asserted: request dropped, no ack.
- Walk covering all 28 cubes:
  - level_done rises in the cycle after the last new cube commits; visited_cnt = 28.
  - Revisiting a cube does not increment the count.
- Assert e_start mid-MOVING:
  - Next cycle position = 1, visited = 1, e_jump_qb = 0, state IDLE.
- Assert reset low asynchronously mid-ISSUE:
  - Outputs reach their reset values without waiting for a clock edge.
